mmio_uart_tx: RTL and testbench
===============================

MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 Parameter: BASE_ADDR, 32'hFFFF_0000, base of the 3-register window on the pipeline data bus.
REQ-002 Parameter: DIV_RESET, 16'd434, baud divisor after reset.
REQ-003 Port: clk, input, 1, single clock; all state on rising edge.
REQ-004 Port: rst, input, 1, asynchronous, active-low reset (asserted at 0).
REQ-005 Port: d_read_en, input, 1, pipeline data-read strobe.
REQ-006 Port: d_write_en, input, 1, pipeline data-write strobe.
REQ-007 Port: d_addr, input, 32, pipeline data address.
REQ-008 Port: d_write_data, input, 32, pipeline store data.
REQ-009 Port: mmio_rdata, output, 32, read data, combinational, valid in the same cycle as d_read_en.
REQ-010 Port: mmio_sel, output, 1, high when d_addr is in BASE_ADDR..BASE_ADDR+8 word-aligned, combinational; the top level muxes mmio_rdata onto d_data_in when high.
REQ-011 Port: uart_tx, output, 1, serial line, idle high.
REQ-012 Port: tx_irq, output, 1, registered, high while the FIFO is empty and the FSM is IDLE.

Function
REQ-013 Register map (word offsets): +0 TXDATA (write only, reads 0), +4 STATUS (read; write clears), +8 DIV (read/write, bits 15:0).
REQ-014 STATUS read: bit0 fifo_full, bit1 fifo_empty, bit2 busy (FSM not IDLE), bit3 overflow (sticky), bits 31:4 zero.
REQ-015 Write to STATUS with d_write_data[3]=1 clears overflow; other bits ignored.
REQ-016 Write to TXDATA pushes d_write_data[7:0] into an 8-entry FIFO; bits 31:8 ignored.
REQ-017 A push is accepted when count<8, or when count==8 and a pop occurs in the same cycle; otherwise the byte is dropped and overflow sets on the next edge.
REQ-018 FIFO count is 4 bits (0..8); pointers are 3 bits and wrap 7->0.
REQ-019 Write to DIV loads d_write_data[15:0]; values 0 or 1 are stored as 2; the new value takes effect at the next bit boundary.
REQ-020 Any access with mmio_sel=0, unaligned address (d_addr[1:0]!=0) or offset >8 is ignored; mmio_rdata=0 when mmio_sel=0 or d_read_en=0.
REQ-021 Simultaneous d_read_en and d_write_en to the same register: the read returns the pre-write value.
REQ-022 FSM states: IDLE, START, DATA, STOP.
REQ-023 IDLE: uart_tx=1; when the FIFO is non-empty, pop the head into the shift register and go to START on the next edge.
REQ-024 START: uart_tx=0 for DIV cycles, then DATA.
REQ-025 DATA: 8 bits LSB first, each held for DIV cycles; a 3-bit bit counter goes from 0 to 7, then STOP.
REQ-026 STOP: uart_tx=1 for DIV cycles, then IDLE; back-to-back bytes therefore add one IDLE cycle between frames.
REQ-027 Frame length: 10*DIV cycles plus 1 IDLE cycle.
REQ-028 Bit timer: a 16-bit down-counter loaded with DIV-1 on entry to each bit, which advances state at 0.
REQ-029 uart_tx is driven from a flop (glitch-free); it falls one cycle after the pop.

Reset
REQ-030 While rst=0: FSM=IDLE, FIFO empty (pointers and count 0), overflow=0, DIV=DIV_RESET, uart_tx=1, tx_irq=1, bit timer and bit counter 0.
REQ-031 Reset asserted mid-frame aborts the frame immediately (uart_tx=1 asynchronously); FIFO contents are discarded.
REQ-032 First bus access is honoured on the first rising edge after rst deasserts.

Verification
REQ-033 DIV=4, write TXDATA=0x00000055 -> uart_tx: 0 (4 cyc), 1,0,1,0,1,0,1,0 (4 cyc each), 1 (4 cyc); busy=1 during frame; tx_irq=1 after.
REQ-034 Write 9 bytes 0x01..0x09 in consecutive cycles while IDLE -> first pop frees a slot, all 9 accepted; then write 9 more in consecutive cycles -> STATUS reads full=1, overflow=1.
REQ-035 Write STATUS=0x8 -> overflow reads 0 next cycle; other bits unchanged.
REQ-036 Write DIV=0 -> DIV reads 2; write DIV=0x12345 -> reads 0x2345.
REQ-037 Assert rst=0 in the middle of the DATA bit 3 -> uart_tx=1 in the same cycle, STATUS=0x2, DIV=434.
REQ-038 Read at BASE_ADDR+0xC and at BASE_ADDR+2 -> mmio_rdata=0, no state change; mmio_sel=0 for 0x0000_1000.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with an 8-entry byte FIFO.
//
// Register window (word offsets from BASE_ADDR):
//   +0 TXDATA  write pushes d_write_data[7:0]; reads 0
//   +4 STATUS  {28'b0, overflow, busy, fifo_empty, fifo_full}; write bit3=1 clears overflow
//   +8 DIV     baud divisor (cycles per bit), bits 15:0; 0/1 are stored as 2
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   d_read_en         pipeline data-read strobe
//   d_write_en        pipeline data-write strobe
//   d_addr            pipeline data address
//   d_write_data      pipeline store data
//   mmio_rdata        combinational read data (0 unless selected and reading)
//   mmio_sel          combinational window hit (aligned, offset 0/4/8)
//   uart_tx           serial line, idle high, driven from a flop
//   tx_irq            registered: FIFO empty and transmitter idle
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
    parameter logic [15:0] DIV_RESET = 16'd434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        d_read_en,
    input  logic        d_write_en,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_write_data,
    output logic [31:0] mmio_rdata,
    output logic        mmio_sel,
    output logic        uart_tx,
    output logic        tx_irq
);
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_fifo [8];
    logic [2:0]  r_wptr, r_rptr;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic        r_ovf;
    logic [15:0] r_div, r_timer, w_timer_nxt;
    logic [2:0]  r_bitcnt, w_bitcnt_nxt;
    logic [7:0]  r_shift, w_shift_nxt;
    logic        r_tx, w_tx_nxt;
    logic        r_irq, w_irq_nxt;

    logic [31:0] w_off;
    logic        w_wr_tx, w_wr_st, w_wr_div;
    logic        w_full, w_empty, w_busy;
    logic        w_pop, w_push, w_drop;
    logic [15:0] w_div_wr;
    logic        w_unused;

    // Address decode: only aligned offsets 0, 4 and 8 hit the window.
    assign w_off    = d_addr - BASE_ADDR;
    assign mmio_sel = (d_addr[1:0] == 2'b00) && (w_off <= 32'd8);
    assign w_wr_tx  = d_write_en && mmio_sel && (w_off[3:2] == 2'd0);
    assign w_wr_st  = d_write_en && mmio_sel && (w_off[3:2] == 2'd1);
    assign w_wr_div = d_write_en && mmio_sel && (w_off[3:2] == 2'd2);

    assign w_full   = (r_cnt == 4'd8);
    assign w_empty  = (r_cnt == 4'd0);
    assign w_busy   = (r_state != S_IDLE);

    // The transmitter takes the head byte whenever it sits idle; a push into a
    // full FIFO still fits if that pop frees a slot in the same cycle.
    assign w_pop    = (r_state == S_IDLE) && !w_empty;
    assign w_push   = w_wr_tx && (!w_full || w_pop);
    assign w_drop   = w_wr_tx && !w_push;

    // Divisors below 2 would leave the bit timer no room to count.
    assign w_div_wr = (d_write_data[15:1] == 15'd0) ? 16'd2 : d_write_data[15:0];

    assign w_unused = &{1'b0, d_write_data[31:16]};

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_push && !w_pop)
            w_cnt_nxt = r_cnt + 4'd1;
        else if (!w_push && w_pop)
            w_cnt_nxt = r_cnt - 4'd1;
    end

    // Read mux reflects pre-edge state, so a read paired with a write to the
    // same register returns the old value.
    always_comb begin
        mmio_rdata = 32'd0;
        if (d_read_en && mmio_sel) begin
            case (w_off[3:2])
                2'd1:    mmio_rdata = {28'd0, r_ovf, w_busy, w_empty, w_full};
                2'd2:    mmio_rdata = {16'd0, r_div};
                default: mmio_rdata = 32'd0;
            endcase
        end
    end

    // FIFO storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (w_push)
            r_fifo[r_wptr] <= d_write_data[7:0];
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_wptr   <= 3'd0;
            r_rptr   <= 3'd0;
            r_cnt    <= 4'd0;
            r_ovf    <= 1'b0;
            r_div    <= DIV_RESET;
            r_timer  <= 16'd0;
            r_bitcnt <= 3'd0;
            r_shift  <= 8'd0;
            r_tx     <= 1'b1;
            r_irq    <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_timer  <= w_timer_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_shift  <= w_shift_nxt;
            r_tx     <= w_tx_nxt;
            r_irq    <= w_irq_nxt;
            r_cnt    <= w_cnt_nxt;
            if (w_push)
                r_wptr <= r_wptr + 3'd1;
            if (w_pop)
                r_rptr <= r_rptr + 3'd1;
            if (w_drop)
                r_ovf <= 1'b1;
            else if (w_wr_st && d_write_data[3])
                r_ovf <= 1'b0;
            if (w_wr_div)
                r_div <= w_div_wr;
        end
    end

    // Next-state: each bit lasts r_div cycles; the timer is reloaded on every
    // bit boundary, which is where a new divisor takes effect.
    always_comb begin
        w_state_nxt  = r_state;
        w_timer_nxt  = r_timer;
        w_bitcnt_nxt = r_bitcnt;
        w_shift_nxt  = r_shift;
        case (r_state)
            S_IDLE: begin
                if (w_pop) begin
                    w_state_nxt = S_START;
                    w_timer_nxt = r_div - 16'd1;
                    w_shift_nxt = r_fifo[r_rptr];
                end
            end
            S_START: begin
                if (r_timer == 16'd0) begin
                    w_state_nxt  = S_DATA;
                    w_timer_nxt  = r_div - 16'd1;
                    w_bitcnt_nxt = 3'd0;
                end else begin
                    w_timer_nxt = r_timer - 16'd1;
                end
            end
            S_DATA: begin
                if (r_timer == 16'd0) begin
                    w_timer_nxt = r_div - 16'd1;
                    if (r_bitcnt == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_bitcnt_nxt = r_bitcnt + 3'd1;
                        w_shift_nxt  = {1'b0, r_shift[7:1]};
                    end
                end else begin
                    w_timer_nxt = r_timer - 16'd1;
                end
            end
            S_STOP: begin
                if (r_timer == 16'd0) begin
                    w_state_nxt = S_IDLE;
                    w_timer_nxt = 16'd0;
                end else begin
                    w_timer_nxt = r_timer - 16'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are computed from next-state values and registered, so the line
    // and the interrupt line up with the state they describe.
    always_comb begin
        case (w_state_nxt)
            S_START: w_tx_nxt = 1'b0;
            S_DATA:  w_tx_nxt = w_shift_nxt[0];
            default: w_tx_nxt = 1'b1;
        endcase
        w_irq_nxt = (w_state_nxt == S_IDLE) && (w_cnt_nxt == 4'd0);
    end

    assign uart_tx = r_tx;
    assign tx_irq  = r_irq;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: the reference model holds the FIFO as a byte queue
// and the serial line as a queue of expected per-cycle line levels.
module tb_mmio_uart_tx;
    localparam logic [31:0] BASE = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        d_read_en = 1'b0;
    logic        d_write_en = 1'b0;
    logic [31:0] d_addr = 32'd0;
    logic [31:0] d_write_data = 32'd0;
    logic [31:0] mmio_rdata;
    logic        mmio_sel;
    logic        uart_tx;
    logic        tx_irq;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    logic [7:0] q[$];
    bit         wave[$];
    bit         ovf_m = 1'b0;
    int         div_m = 434;

    mmio_uart_tx #(.BASE_ADDR(BASE), .DIV_RESET(16'd434)) dut (
        .clk(clk), .rst(rst),
        .d_read_en(d_read_en), .d_write_en(d_write_en),
        .d_addr(d_addr), .d_write_data(d_write_data),
        .mmio_rdata(mmio_rdata), .mmio_sel(mmio_sel),
        .uart_tx(uart_tx), .tx_irq(tx_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic bit sel_m(input logic [31:0] a);
        logic [31:0] o;
        o = a - BASE;
        return (a[1:0] == 2'b00) && (o <= 32'd8);
    endfunction

    function automatic logic [31:0] rd_m(input logic rd, input logic [31:0] a);
        logic [31:0] o;
        o = a - BASE;
        if (!rd || !sel_m(a)) return 32'd0;
        if (o == 32'd4)
            return {28'd0, ovf_m, wave.size() != 0, q.size() == 0, q.size() == 8};
        if (o == 32'd8)
            return div_m;
        return 32'd0;
    endfunction

    function automatic void model_reset();
        q.delete();
        wave.delete();
        ovf_m = 1'b0;
        div_m = 434;
    endfunction

    // One bus cycle: drive, check everything observable, then advance the model
    // across the coming rising edge.
    task automatic cyc(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] o;
        logic [7:0]  b;
        bit          idle;
        @(negedge clk);
        d_read_en = rd; d_write_en = wr; d_addr = a; d_write_data = wd;
        #1;
        chk("uart_tx", uart_tx, (wave.size() != 0) ? wave[0] : 1'b1);
        chk("tx_irq", tx_irq, (q.size() == 0) && (wave.size() == 0));
        chk("mmio_sel", mmio_sel, sel_m(a));
        chk("mmio_rdata", mmio_rdata, rd_m(rd, a));
        idle = (wave.size() == 0);
        if (!idle) wave.delete(0);
        if (idle && q.size() != 0) begin
            b = q.pop_front();
            repeat (div_m) wave.push_back(1'b0);
            for (int i = 0; i < 8; i++) repeat (div_m) wave.push_back(b[i]);
            repeat (div_m) wave.push_back(1'b1);
        end
        if (wr && sel_m(a)) begin
            o = a - BASE;
            if (o == 32'd0) begin
                if (q.size() < 8) q.push_back(wd[7:0]);
                else ovf_m = 1'b1;
            end else if (o == 32'd4) begin
                if (wd[3]) ovf_m = 1'b0;
            end else begin
                div_m = (wd[15:0] < 16'd2) ? 2 : int'(wd[15:0]);
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 4000 && (q.size() != 0 || wave.size() != 0); i++)
            cyc(1'b1, 1'b0, BASE + 32'd4, 32'd0);
        chk("drain_timeout", q.size() + wave.size(), 32'd0);
    endtask

    function automatic logic [31:0] pick_addr(input int k);
        case (k)
            0: return BASE;
            1: return BASE + 32'd4;
            2: return BASE + 32'd8;
            3: return BASE + 32'hC;
            4: return BASE + 32'd2;
            5: return 32'h0000_1000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        // Reset values while held in reset
        repeat (3) @(negedge clk);
        d_read_en = 1'b1; d_addr = BASE + 32'd4;
        #1;
        chk("rst_tx", uart_tx, 1'b1);
        chk("rst_irq", tx_irq, 1'b1);
        chk("rst_status", mmio_rdata, 32'h2);
        d_addr = BASE + 32'd8;
        #1;
        chk("rst_div", mmio_rdata, 32'd434);
        @(negedge clk);
        rst = 1'b1;
        d_read_en = 1'b0;

        // First access right after reset, then a 0x55 frame at DIV=4
        cyc(1'b0, 1'b1, BASE + 32'd8, 32'd4);
        cyc(1'b1, 1'b0, BASE + 32'd8, 32'd0);
        cyc(1'b0, 1'b1, BASE, 32'hFFFF_FF55);
        repeat (45) cyc(1'b1, 1'b0, BASE + 32'd4, 32'd0);

        // Nine back-to-back pushes all fit, nine more overflow
        for (int i = 1; i <= 9; i++) cyc(1'b0, 1'b1, BASE, i);
        for (int i = 1; i <= 9; i++) cyc(1'b0, 1'b1, BASE, 32'h10 + i);
        cyc(1'b1, 1'b0, BASE + 32'd4, 32'd0);
        chk("full_ovf", mmio_rdata & 32'h9, 32'h9);
        // Read with clearing write returns the old value; next read shows it cleared
        cyc(1'b1, 1'b1, BASE + 32'd4, 32'h8);
        cyc(1'b1, 1'b0, BASE + 32'd4, 32'd0);
        chk("ovf_clear", mmio_rdata & 32'h9, 32'h1);
        drain();

        // Divisor clamping and truncation
        cyc(1'b0, 1'b1, BASE + 32'd8, 32'd0);
        cyc(1'b1, 1'b0, BASE + 32'd8, 32'd0);
        chk("div_clamp", mmio_rdata, 32'd2);
        cyc(1'b0, 1'b1, BASE + 32'd8, 32'h12345);
        cyc(1'b1, 1'b0, BASE + 32'd8, 32'd0);
        chk("div_trunc", mmio_rdata, 32'h2345);
        cyc(1'b0, 1'b1, BASE + 32'd8, 32'd4);

        // Out-of-window and unaligned accesses
        cyc(1'b1, 1'b1, BASE + 32'hC, 32'hFF);
        cyc(1'b1, 1'b1, BASE + 32'd2, 32'hFF);
        cyc(1'b1, 1'b1, BASE + 32'd10, 32'h1);
        cyc(1'b1, 1'b0, 32'h0000_1000, 32'd0);
        cyc(1'b1, 1'b0, BASE + 32'd4, 32'd0);
        cyc(1'b1, 1'b0, BASE + 32'd8, 32'd0);

        // Reset in the middle of data bit 3 of 0xA5 (bit 3 is 0)
        cyc(1'b0, 1'b1, BASE, 32'hA5);
        repeat (18) cyc(1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        d_read_en = 1'b1; d_write_en = 1'b0; d_addr = BASE + 32'd4;
        #1;
        chk("bit3_before_rst", uart_tx, 1'b0);
        rst = 1'b0;
        #1;
        chk("midrst_tx", uart_tx, 1'b1);
        chk("midrst_irq", tx_irq, 1'b1);
        chk("midrst_status", mmio_rdata, 32'h2);
        d_addr = BASE + 32'd8;
        #1;
        chk("midrst_div", mmio_rdata, 32'd434);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        d_read_en = 1'b0;
        cyc(1'b0, 1'b1, BASE + 32'd8, 32'd3);

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            logic [31:0] a, wd;
            logic        rd, wr;
            a  = pick_addr($urandom_range(0, 6));
            if ($urandom_range(0, 3) == 0) a = BASE;
            rd = 1'($urandom_range(0, 1));
            wr = ($urandom_range(0, 2) == 0);
            wd = $urandom;
            if (a == BASE + 32'd8) begin
                if (q.size() != 0 || wave.size() != 0) wr = 1'b0;
                wd = $urandom_range(0, 5);
            end
            cyc(rd, wr, a, wd);
        end
        drain();
        cyc(1'b1, 1'b0, BASE + 32'd4, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
